passthrough_rr_arbiter: RTL and testbench

- Shares one registered 10-bit passthrough lane between N requesters using valid/ready handshakes.
- Selection is round-robin. A winner holds the lane for a burst of up to BURST beats.
- Sits in front of the passthrough datapath and sequences which source drives the lane each cycle.

---
 rtl/passthrough_arb_pkg.sv | 17 +
 rtl/rr_priority_pick.sv | 48 ++++
 rtl/passthrough_rr_arbiter.sv | 130 +++++++++++++
 tb/tb_passthrough_rr_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/passthrough_arb_pkg.sv
// Shared types and helpers for the round-robin passthrough arbiter.
package passthrough_arb_pkg;

  localparam int unsigned W_DEFAULT = 10;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  // Index width; a 2-entry space still needs one bit.
  function automatic int unsigned idx_clog2(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin priority pick: rotate requests by ptr, take the first set bit, un-rotate.
module rr_priority_pick
  import passthrough_arb_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] sel_o,
  output logic          any_o
);

  logic [N-1:0] rot;
  int unsigned  ptr_ext;
  int unsigned  j;
  int unsigned  off;
  int unsigned  sum;
  logic         found;

  assign ptr_ext = 32'(ptr_i);
  assign any_o   = |req_i;

  always_comb begin
    rot = '0;
    j   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = ptr_ext + k;
      if (j >= N) j = j - N;
      rot[k] = req_i[j[IW-1:0]];
    end
  end

  always_comb begin
    off   = 0;
    found = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        off   = k;
      end
    end
    sum = ptr_ext + off;
    if (sum >= N) sum = sum - N;
    sel_o = sum[IW-1:0];
  end

endmodule

// File: rtl/passthrough_rr_arbiter.sv
// Round-robin arbiter with burst locking in front of a single registered passthrough lane.
module passthrough_rr_arbiter
  import passthrough_arb_pkg::*;
#(
  parameter  int unsigned N     = 4,
  parameter  int unsigned W     = W_DEFAULT,
  parameter  int unsigned BURST = 4,
  localparam int unsigned IW    = idx_clog2(N)
) (
  input  logic           clock,
  input  logic           reset,
  input  logic [N-1:0]   io_in_valid,
  output logic [N-1:0]   io_in_ready,
  input  logic [N*W-1:0] io_in_bits,
  output logic           io_out_valid,
  input  logic           io_out_ready,
  output logic [W-1:0]   io_out_bits,
  output logic [IW-1:0]  io_grant_idx,
  output logic           io_busy
);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_bits_q, out_bits_d;

  logic [W-1:0]  lane [N];
  logic [IW-1:0] pick_sel;
  logic          pick_any;
  logic [IW-1:0] sel;
  logic          have_sel;
  logic          can_load;
  logic          xfer;

  always_comb begin
    for (int unsigned i = 0; i < N; i++) lane[i] = io_in_bits[i*W +: W];
  end

  rr_priority_pick #(.N(N), .IW(IW)) u_pick (
    .req_i (io_in_valid),
    .ptr_i (ptr_q),
    .sel_o (pick_sel),
    .any_o (pick_any)
  );

  assign can_load = !out_valid_q || io_out_ready;
  assign sel      = (state_q == LOCKED) ? owner_q : pick_sel;
  assign have_sel = (state_q == LOCKED) || pick_any;
  assign xfer     = have_sel && can_load && io_in_valid[sel];

  // Gated by reset so the handshake drops the moment reset asserts, not at the next edge.
  always_comb begin
    io_in_ready = '0;
    if (reset && have_sel && can_load) io_in_ready[sel] = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bits_d  = out_bits_q;

    unique case (state_q)
      IDLE: begin
        if (xfer) begin
          owner_d = sel;
          grant_d = sel;
          cnt_d   = 4'd1;
          if (BURST == 1) ptr_d = IW'(wrap_inc(32'(sel), N));
          else            state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (!io_in_valid[owner_q]) begin
          state_d = IDLE;
          ptr_d   = IW'(wrap_inc(32'(owner_q), N));
          cnt_d   = '0;
        end else if (xfer) begin
          if (32'(cnt_q) + 1 == BURST) begin
            state_d = IDLE;
            ptr_d   = IW'(wrap_inc(32'(owner_q), N));
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (xfer) begin
      out_valid_d = 1'b1;
      out_bits_d  = lane[sel];
    end else if (io_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      owner_q     <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bits_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bits_q  <= out_bits_d;
    end
  end

  assign io_out_valid = out_valid_q;
  assign io_out_bits  = out_bits_q;
  assign io_grant_idx = grant_q;
  assign io_busy      = (state_q == LOCKED) || out_valid_q;

endmodule

// File: tb/tb_passthrough_rr_arbiter.sv
// Drives a BURST=4 and a BURST=1 arbiter with identical stimulus and checks both against a beat-level model.
module tb_passthrough_rr_arbiter;

  localparam int N = 4;
  localparam int W = 10;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   in_valid = '0;
  logic [N*W-1:0] in_bits = '0;
  logic           out_ready = 1'b0;

  logic [N-1:0] rdy  [2];
  logic         ov   [2];
  logic [W-1:0] ob   [2];
  logic [1:0]   gi   [2];
  logic         busy [2];

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  passthrough_rr_arbiter #(.N(N), .W(W), .BURST(4)) dut4 (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(rdy[0]),
    .io_in_bits(in_bits), .io_out_valid(ov[0]), .io_out_ready(out_ready),
    .io_out_bits(ob[0]), .io_grant_idx(gi[0]), .io_busy(busy[0])
  );

  passthrough_rr_arbiter #(.N(N), .W(W), .BURST(1)) dut1 (
    .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in_ready(rdy[1]),
    .io_in_bits(in_bits), .io_out_valid(ov[1]), .io_out_ready(out_ready),
    .io_out_bits(ob[1]), .io_grant_idx(gi[1]), .io_busy(busy[1])
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Model: per arbiter, a lock flag with beats remaining instead of a counter.
  int           bm      [2] = '{4, 1};
  int           m_ptr   [2];
  int           m_owner [2];
  int           m_left  [2];
  int           m_grant [2];
  bit           m_lock  [2];
  bit           m_ov    [2];
  logic [W-1:0] m_ob    [2];

  function automatic logic [N*W-1:0] pack(input int d0, input int d1, input int d2, input int d3);
    logic [N*W-1:0] p;
    p = {W'(d3), W'(d2), W'(d1), W'(d0)};
    return p;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      m_ptr[m] = 0; m_owner[m] = 0; m_left[m] = 0; m_grant[m] = 0;
      m_lock[m] = 0; m_ov[m] = 0; m_ob[m] = '0;
    end
  endtask

  task automatic step();
    for (int m = 0; m < 2; m++) begin
      bit             cl;
      bit             x;
      int             s;
      logic [N-1:0]   er;
      cl = !m_ov[m] || out_ready;
      s  = -1;
      if (m_lock[m]) s = m_owner[m];
      else
        for (int k = 0; k < N; k++)
          if (s < 0 && in_valid[(m_ptr[m] + k) % N]) s = (m_ptr[m] + k) % N;
      er = '0;
      if (s >= 0 && cl) er[s] = 1'b1;
      check($sformatf("ready[%0d]", m), 32'(rdy[m]), 32'(er));
      x = (s >= 0) && cl && in_valid[s];
      if (m_lock[m] && !in_valid[s]) begin
        m_lock[m] = 0;
        m_ptr[m]  = (s + 1) % N;
      end
      if (x) begin
        m_ov[m]    = 1;
        m_ob[m]    = in_bits[s*W +: W];
        m_grant[m] = s;
        m_owner[m] = s;
        if (!m_lock[m]) begin
          if (bm[m] == 1) m_ptr[m] = (s + 1) % N;
          else begin
            m_lock[m] = 1;
            m_left[m] = bm[m] - 1;
          end
        end else begin
          m_left[m]--;
          if (m_left[m] == 0) begin
            m_lock[m] = 0;
            m_ptr[m]  = (s + 1) % N;
          end
        end
      end else if (out_ready) begin
        m_ov[m] = 0;
      end
    end
  endtask

  task automatic check_regs();
    for (int m = 0; m < 2; m++) begin
      check($sformatf("out_valid[%0d]", m), 32'(ov[m]), 32'(m_ov[m]));
      check($sformatf("out_bits[%0d]", m), 32'(ob[m]), 32'(m_ob[m]));
      check($sformatf("grant_idx[%0d]", m), 32'(gi[m]), 32'(m_grant[m]));
      check($sformatf("busy[%0d]", m), 32'(busy[m]), 32'(m_lock[m] || m_ov[m]));
    end
  endtask

  // Called just after a falling edge; inputs apply to the next rising edge.
  task automatic cycle(input logic [N-1:0] v, input logic [N*W-1:0] b, input logic r);
    in_valid  = v;
    in_bits   = b;
    out_ready = r;
    #1;
    step();
    @(negedge clock);
    check_regs();
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, 1'b1);
  endtask

  initial begin
    model_reset();
    in_valid = 4'hF;
    repeat (2) @(negedge clock);
    check_regs();
    check("reset_ready[0]", 32'(rdy[0]), 32'h0);
    check("reset_ready[1]", 32'(rdy[1]), 32'h0);
    in_valid = '0;
    reset    = 1'b1;

    for (int k = 1; k <= 6; k++) cycle(4'b0100, pack(0, 0, k, 0), 1'b1);
    check("single_grant", 32'(gi[0]), 32'd2);
    drain(2);

    for (int k = 0; k < 8; k++) cycle(4'hF, pack(12'h100, 12'h101, 12'h102, 12'h103), 1'b1);
    drain(2);

    cycle(4'b0001, pack(12'h2AA, 0, 0, 0), 1'b1);
    for (int k = 0; k < 3; k++) begin
      cycle(4'b0001, pack(12'h155, 0, 0, 0), 1'b0);
      check("bp_hold", 32'(ob[0]), 32'h2AA);
    end
    cycle(4'b0001, pack(12'h155, 0, 0, 0), 1'b1);
    check("bp_resume", 32'(ob[0]), 32'h155);
    drain(2);

    cycle(4'b0010, pack(0, 12'h011, 0, 0), 1'b1);
    cycle(4'b0010, pack(0, 12'h012, 0, 0), 1'b1);
    for (int k = 0; k < 3; k++) cycle(4'b1000, pack(0, 0, 0, 12'h030 + k), 1'b1);
    check("early_release_grant", 32'(gi[0]), 32'd3);
    drain(2);

    for (int k = 0; k < 7; k++) cycle(4'b1001, pack(12'h0A0 + k, 0, 0, 12'h0B0 + k), 1'b1);
    drain(2);

    cycle(4'b0010, pack(0, 12'h077, 0, 0), 1'b1);
    cycle(4'b0010, pack(0, 12'h078, 0, 0), 1'b1);
    #2 reset = 1'b0;
    #1;
    for (int m = 0; m < 2; m++) begin
      check($sformatf("async_rst_valid[%0d]", m), 32'(ov[m]), 32'h0);
      check($sformatf("async_rst_ready[%0d]", m), 32'(rdy[m]), 32'h0);
      check($sformatf("async_rst_busy[%0d]", m), 32'(busy[m]), 32'h0);
    end
    model_reset();
    @(negedge clock);
    reset = 1'b1;
    cycle(4'b1010, pack(0, 12'h0C1, 0, 12'h0C3), 1'b1);
    check("post_rst_grant", 32'(gi[0]), 32'd1);
    drain(2);

    for (int k = 0; k < 400; k++) begin
      logic [N*W-1:0] b;
      for (int i = 0; i < N; i++) b[i*W +: W] = W'($urandom);
      cycle(N'($urandom_range(0, 15) | $urandom_range(0, 15)) & N'($urandom_range(0, 15)),
            b, ($urandom_range(0, 3) != 0));
    end
    drain(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
